rr_mux_sel_arbiter: RTL

Round-robin arbiter that drives the 2-bit select of the 4:1 channel mux. It sits directly upstream of the mux. Four request lines, one per mux input a/b/c/d (index 0..3), compete for the output. The block grants one channel at a time for a programmable dwell period and presents the winner as a registered `sel` plus a valid flag.

---
 rtl/rr_mux_sel_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter producing the registered 2-bit select for the 4:1 channel mux.
// Latency: a request sampled on an edge is granted on that same edge (outputs registered, 1 cycle).
// Backpressure: none; a grant is held for dwell+1 cycles or until its requester drops.
// Optional feature macro: ARB_LOCK_EN adds a lock input that suppresses dwell expiry.
module rr_mux_sel_arbiter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [DWELL_W-1:0] dwell,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [1:0]         sel,
  output logic [3:0]         grant,
  output logic               grant_valid,
  output logic               switch_pulse
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t             state, state_nxt;
  logic [1:0]         last;
  logic [1:0]         win;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [1:0]         sel_nxt;
  logic [3:0]         grant_nxt;
  logic               valid_nxt;
  logic               pulse_nxt;
  logic               lock_eff;
  logic               expire;
  logic               drop;
  logic               load;

`ifdef ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  // Expiry is masked while locked; a dropped requester always releases the grant.
  assign expire = (cnt == '0) && !lock_eff;
  assign drop   = !req[sel];

  // Search order last+1, last+2, last+3, last: lowest priority written first, highest last.
  always_comb begin
    win = last;
    for (int k = 3; k >= 1; k--) begin
      if (req[last + 2'(k)]) win = last + 2'(k);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and load decision: a trigger with any request re-arbitrates, otherwise go idle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (expire || drop) begin
          if (|req) load = 1'b1;
          else      state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the saturating dwell counter.
  always_comb begin
    sel_nxt = sel;
    cnt_nxt = cnt;
    if (load) begin
      sel_nxt = win;
      cnt_nxt = dwell;
    end else if (state == HOLD && cnt != '0) begin
      cnt_nxt = cnt - CNT_ONE;
    end
    valid_nxt = (state_nxt == HOLD);
    grant_nxt = valid_nxt ? (4'b0001 << sel_nxt) : 4'b0000;
    pulse_nxt = valid_nxt && (sel_nxt != sel);
  end

  // Output, pointer and counter registers; last starts at 3 so the first search begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel          <= 2'd0;
      grant        <= 4'b0000;
      grant_valid  <= 1'b0;
      switch_pulse <= 1'b0;
      last         <= 2'd3;
      cnt          <= '0;
    end else begin
      sel          <= sel_nxt;
      grant        <= grant_nxt;
      grant_valid  <= valid_nxt;
      switch_pulse <= pulse_nxt;
      cnt          <= cnt_nxt;
      if (load) last <= win;
    end
  end

endmodule
